alu_iter: RTL

ALU_ITER -- requirements
Module: alu_iter

---
 rtl/alu_iter.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/alu_iter.sv
// Iterative ALU: single-cycle logic/arithmetic ops, multi-cycle shift-add multiply
// and restoring divide, behind a valid/ready request/response handshake.
module alu_iter #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] B,
    input  logic [3:0]            ALUop,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] Result,
    output logic                  Overflow,
    output logic                  CarryOut,
    output logic                  Zero
);

    localparam int unsigned W  = DATA_WIDTH;
    localparam int unsigned CW = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    typedef enum logic [3:0] {
        OP_AND  = 4'b0000,
        OP_OR   = 4'b0001,
        OP_ADD  = 4'b0010,
        OP_SLTU = 4'b0011,
        OP_XOR  = 4'b0100,
        OP_NOR  = 4'b0101,
        OP_SUB  = 4'b0110,
        OP_SLT  = 4'b0111,
        OP_MUL  = 4'b1000,
        OP_DIVU = 4'b1001,
        OP_REMU = 4'b1010
    } op_t;

    state_t         state_q, state_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    logic [W-1:0]   acc_q, acc_d;
    logic [W-1:0]   res_q, res_d;
    logic [3:0]     op_q, op_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           ovf_q, ovf_d;
    logic           cout_q, cout_d;
    logic           zero_q, zero_d;

    // Single-cycle datapath, evaluated on the live inputs at the accept edge
    logic [W:0]     sum_w, dif_w;
    logic           add_ovf, sub_ovf, slt_bit;
    logic [W-1:0]   alu_res;
    logic           alu_ovf, alu_cout, alu_legal, alu_iter;

    always_comb begin
        sum_w   = {1'b0, A} + {1'b0, B};
        dif_w   = {1'b0, A} - {1'b0, B};
        add_ovf = (A[W-1] == B[W-1]) && (sum_w[W-1] != A[W-1]);
        sub_ovf = (A[W-1] != B[W-1]) && (dif_w[W-1] != A[W-1]);
        // True signed compare: the difference sign is inverted when the subtraction overflows
        slt_bit = dif_w[W-1] ^ sub_ovf;

        alu_res   = '0;
        alu_ovf   = 1'b0;
        alu_cout  = 1'b0;
        alu_legal = 1'b1;
        alu_iter  = 1'b0;
        case (ALUop)
            OP_AND:  alu_res = A & B;
            OP_OR:   alu_res = A | B;
            OP_XOR:  alu_res = A ^ B;
            OP_NOR:  alu_res = ~(A | B);
            OP_ADD: begin
                alu_res  = sum_w[W-1:0];
                alu_cout = sum_w[W];
                alu_ovf  = add_ovf;
            end
            OP_SUB: begin
                alu_res  = dif_w[W-1:0];
                alu_cout = dif_w[W];
                alu_ovf  = sub_ovf;
            end
            OP_SLT:  alu_res = {{(W-1){1'b0}}, slt_bit};
            OP_SLTU: alu_res = {{(W-1){1'b0}}, dif_w[W]};
            OP_MUL, OP_DIVU, OP_REMU: alu_iter = 1'b1;
            default: alu_legal = 1'b0;
        endcase
    end

    // One iteration step; a_q/b_q serve as multiplicand/multiplier or quotient/divisor
    logic [W-1:0]   mul_acc, mul_a, mul_b;
    logic [W:0]     rem_sh, trial;
    logic [W-1:0]   div_rem, div_quo;
    logic [W-1:0]   iter_res;

    always_comb begin
        mul_acc = acc_q + (b_q[0] ? a_q : '0);
        mul_a   = a_q << 1;
        mul_b   = b_q >> 1;

        rem_sh  = {acc_q, a_q[W-1]};
        trial   = rem_sh - {1'b0, b_q};
        if (!trial[W]) begin
            div_rem = trial[W-1:0];
            div_quo = {a_q[W-2:0], 1'b1};
        end else begin
            div_rem = rem_sh[W-1:0];
            div_quo = {a_q[W-2:0], 1'b0};
        end

        if (op_q == OP_MUL) begin
            iter_res = mul_acc;
        end else if (op_q == OP_DIVU) begin
            iter_res = div_quo;
        end else begin
            iter_res = div_rem;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        ovf_d   = ovf_q;
        cout_d  = cout_q;
        zero_d  = zero_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d   = A;
                    b_d   = B;
                    op_d  = ALUop;
                    acc_d = '0;
                    cnt_d = '0;
                    if (alu_iter) begin
                        state_d = BUSY;
                    end else begin
                        state_d = DONE;
                        res_d   = alu_res;
                        ovf_d   = alu_ovf;
                        cout_d  = alu_cout;
                        zero_d  = alu_legal && (alu_res == '0);
                    end
                end
            end
            BUSY: begin
                cnt_d = cnt_q + 1'b1;
                if (op_q == OP_MUL) begin
                    acc_d = mul_acc;
                    a_d   = mul_a;
                    b_d   = mul_b;
                end else begin
                    acc_d = div_rem;
                    a_d   = div_quo;
                end
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    res_d   = iter_res;
                    ovf_d   = 1'b0;
                    cout_d  = 1'b0;
                    zero_d  = (iter_res == '0);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            op_q    <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            ovf_q   <= 1'b0;
            cout_q  <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            ovf_q   <= ovf_d;
            cout_q  <= cout_d;
            zero_q  <= zero_d;
        end
    end

    assign in_ready  = resetn && (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign Result    = res_q;
    assign Overflow  = ovf_q;
    assign CarryOut  = cout_q;
    assign Zero      = zero_q;

endmodule
